// File: rtl/banco_registros.sv
// 32-entry MIPS register file: two bypassed combinational read ports, one write
// port from write-back, and a valid/ready dump port that streams every register.
module banco_registros #(
    parameter int len                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int N_REGISTROS          = 32
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic                            i_RegWrite,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
    input  logic [len-1:0]                  i_write_data,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_read_reg1,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_read_reg2,
    output logic [len-1:0]                  o_read_data1,
    output logic [len-1:0]                  o_read_data2,
    input  logic                            i_dump_start,
    input  logic                            i_dump_ready,
    output logic                            o_dump_valid,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_dump_addr,
    output logic [len-1:0]                  o_dump_data,
    output logic                            o_dump_done,
    output logic                            o_busy
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [NB_ADDRESS_REGISTROS-1:0] LAST_IDX = NB_ADDRESS_REGISTROS'(N_REGISTROS - 1);

    logic [N_REGISTROS-1:0][len-1:0]   regs;
    logic                              we;
    state_t                            state;
    logic [NB_ADDRESS_REGISTROS-1:0]   idx;

    // r0 is never written, so it keeps its reset value of zero forever
    assign we = i_enable && i_RegWrite && (i_write_reg != '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            regs <= '0;
        else if (we)
            regs[i_write_reg] <= i_write_data;
    end

    always_comb begin
        o_read_data1 = regs[i_read_reg1];
        o_read_data2 = regs[i_read_reg2];
        if (we && i_write_reg == i_read_reg1)
            o_read_data1 = i_write_data;
        if (we && i_write_reg == i_read_reg2)
            o_read_data2 = i_write_data;
    end

    // Dump data tracks the array directly so a write to the presented entry shows up
    assign o_dump_addr = idx;
    assign o_dump_data = regs[idx];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= IDLE;
            idx          <= '0;
            o_dump_valid <= 1'b0;
            o_dump_done  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_dump_done <= 1'b0;
                    if (i_dump_start) begin
                        state        <= SEND;
                        idx          <= '0;
                        o_dump_valid <= 1'b1;
                        o_busy       <= 1'b1;
                    end
                end
                SEND: begin
                    if (o_dump_valid && i_dump_ready) begin
                        if (idx == LAST_IDX) begin
                            state        <= DONE;
                            o_dump_valid <= 1'b0;
                            o_dump_done  <= 1'b1;
                        end else begin
                            idx <= idx + NB_ADDRESS_REGISTROS'(1);
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    idx         <= '0;
                    o_dump_done <= 1'b0;
                    o_busy      <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    idx          <= '0;
                    o_dump_valid <= 1'b0;
                    o_dump_done  <= 1'b0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_banco_registros.sv
// Directed bench for banco_registros: reset, write/read, r0/enable, bypass,
// dump with backpressure and reset in the middle of a dump.
module tb_banco_registros;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_RegWrite;
    logic [4:0]  i_write_reg;
    logic [31:0] i_write_data;
    logic [4:0]  i_read_reg1;
    logic [4:0]  i_read_reg2;
    logic [31:0] o_read_data1;
    logic [31:0] o_read_data2;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic        o_dump_valid;
    logic [4:0]  o_dump_addr;
    logic [31:0] o_dump_data;
    logic        o_dump_done;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    banco_registros dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_RegWrite(i_RegWrite), .i_write_reg(i_write_reg), .i_write_data(i_write_data),
        .i_read_reg1(i_read_reg1), .i_read_reg2(i_read_reg2),
        .o_read_data1(o_read_data1), .o_read_data2(o_read_data2),
        .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
        .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
        .o_dump_done(o_dump_done), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [31:0] d);
        i_RegWrite = 1'b1; i_write_reg = r; i_write_data = d;
        tick();
        i_RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_enable = 1'b1;
        for (int k = 1; k < 6; k++) do_write(5'(k * 3), $urandom);
        i_reset = 1'b0;
        tick(); tick();
        i_reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            i_read_reg1 = 5'(a); i_read_reg2 = 5'(31 - a);
            #1;
            checks++;
            if (o_read_data1 !== 32'h0 || o_read_data2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_read a=%0d: got %h/%h expected 0/0", a, o_read_data1, o_read_data2);
            end
        end
        checks++;
        if (o_dump_valid !== 1'b0 || o_busy !== 1'b0 || o_dump_done !== 1'b0 ||
            o_dump_addr !== 5'd0 || o_dump_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_dump: got v=%b b=%b d=%b a=%0d data=%h expected 0 0 0 0 0",
                     o_dump_valid, o_busy, o_dump_done, o_dump_addr, o_dump_data);
        end
    endtask

    task automatic test_write_read();
        i_enable = 1'b1;
        do_write(5'd5, 32'h00000010);
        do_write(5'd31, 32'h00000003);
        i_read_reg1 = 5'd5; i_read_reg2 = 5'd31;
        #1;
        checks++;
        if (o_read_data1 !== 32'h00000010 || o_read_data2 !== 32'h00000003) begin
            errors++;
            $display("FAIL write_read: got %h/%h expected 00000010/00000003", o_read_data1, o_read_data2);
        end
    endtask

    task automatic test_reg_zero_enable();
        i_enable = 1'b1;
        i_RegWrite = 1'b1; i_write_reg = 5'd0; i_write_data = 32'hDEADBEEF;
        i_read_reg1 = 5'd0; i_read_reg2 = 5'd0;
        #1;
        checks++;
        if (o_read_data1 !== 32'h0 || o_read_data2 !== 32'h0) begin
            errors++;
            $display("FAIL r0_bypass: got %h/%h expected 0/0", o_read_data1, o_read_data2);
        end
        tick();
        i_RegWrite = 1'b0;
        #1;
        checks++;
        if (o_read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL r0_write: got %h expected 00000000", o_read_data1);
        end
        i_enable = 1'b0;
        i_RegWrite = 1'b1; i_write_reg = 5'd7; i_write_data = 32'h12345678;
        i_read_reg1 = 5'd7; i_read_reg2 = 5'd5;
        #1;
        checks++;
        if (o_read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL disabled_bypass: got %h expected 00000000", o_read_data1);
        end
        tick();
        i_RegWrite = 1'b0;
        #1;
        checks++;
        if (o_read_data1 !== 32'h0 || o_read_data2 !== 32'h00000010) begin
            errors++;
            $display("FAIL disabled_write: got %h/%h expected 00000000/00000010", o_read_data1, o_read_data2);
        end
        i_enable = 1'b1;
    endtask

    task automatic test_bypass();
        i_enable = 1'b1;
        i_RegWrite = 1'b1; i_write_reg = 5'd9; i_write_data = 32'hCAFE0001;
        i_read_reg1 = 5'd9; i_read_reg2 = 5'd9;
        #1;
        checks++;
        if (o_read_data1 !== 32'hCAFE0001 || o_read_data2 !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL bypass_both: got %h/%h expected cafe0001/cafe0001", o_read_data1, o_read_data2);
        end
        tick();
        // write r5 while port1 reads r9 from the array and port2 bypasses r5
        i_write_reg = 5'd5; i_write_data = 32'h0000ABCD;
        i_read_reg2 = 5'd5;
        #1;
        checks++;
        if (o_read_data1 !== 32'hCAFE0001 || o_read_data2 !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL bypass_one: got %h/%h expected cafe0001/0000abcd", o_read_data1, o_read_data2);
        end
        tick();
        i_write_reg = 5'd0; i_write_data = 32'hFFFFFFFF;
        i_read_reg1 = 5'd0; i_read_reg2 = 5'd0;
        #1;
        checks++;
        if (o_read_data1 !== 32'h0 || o_read_data2 !== 32'h0) begin
            errors++;
            $display("FAIL bypass_r0: got %h/%h expected 0/0", o_read_data1, o_read_data2);
        end
        tick();
        i_RegWrite = 1'b0;
    endtask

    task automatic test_dump_backpressure();
        int hs;
        int cyc;
        int done_cnt;
        i_enable = 1'b1;
        for (int k = 1; k < 32; k++) do_write(5'(k), 32'(k * 4));
        i_enable = 1'b0;
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        hs = 0; cyc = 0; done_cnt = 0;
        while (hs < 32 && cyc < 200) begin
            i_dump_ready = cyc[0];
            i_dump_start = (cyc == 6);
            #1;
            checks++;
            if (o_dump_valid !== 1'b1 || o_busy !== 1'b1 || o_dump_done !== 1'b0) begin
                errors++;
                $display("FAIL dump_flags cyc=%0d: got v=%b b=%b d=%b expected 1 1 0",
                         cyc, o_dump_valid, o_busy, o_dump_done);
            end
            checks++;
            if (o_dump_addr !== 5'(hs) || o_dump_data !== 32'(hs * 4)) begin
                errors++;
                $display("FAIL dump_word cyc=%0d: got %0d/%h expected %0d/%h",
                         cyc, o_dump_addr, o_dump_data, hs, 32'(hs * 4));
            end
            if (i_dump_ready) hs++;
            tick();
            cyc++;
        end
        i_dump_ready = 1'b0; i_dump_start = 1'b0;
        checks++;
        if (hs != 32) begin
            errors++;
            $display("FAIL dump_count: got %0d handshakes expected 32", hs);
        end
        if (o_dump_done === 1'b1) done_cnt++;
        checks++;
        if (o_dump_done !== 1'b1 || o_dump_valid !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL dump_done: got d=%b v=%b b=%b expected 1 0 1", o_dump_done, o_dump_valid, o_busy);
        end
        tick();
        if (o_dump_done === 1'b1) done_cnt++;
        checks++;
        if (o_dump_done !== 1'b0 || o_busy !== 1'b0 || o_dump_valid !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL dump_idle: got d=%b b=%b v=%b pulses=%0d expected 0 0 0 1",
                     o_dump_done, o_busy, o_dump_valid, done_cnt);
        end
    endtask

    task automatic test_reset_mid_dump();
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        i_dump_ready = 1'b1;
        for (int k = 0; k <= 10; k++) tick();
        checks++;
        if (o_dump_addr !== 5'd11) begin
            errors++;
            $display("FAIL mid_dump_addr: got %0d expected 11", o_dump_addr);
        end
        i_reset = 1'b0;
        tick();
        checks++;
        if (o_dump_valid !== 1'b0 || o_busy !== 1'b0 || o_dump_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b b=%b d=%b expected 0 0 0", o_dump_valid, o_busy, o_dump_done);
        end
        i_reset = 1'b1;
        tick();
        checks++;
        if (o_dump_done !== 1'b0 || o_dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: got d=%b v=%b expected 0 0", o_dump_done, o_dump_valid);
        end
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (o_dump_valid !== 1'b1 || o_dump_addr !== 5'(k) || o_dump_data !== 32'h0) begin
                errors++;
                $display("FAIL restart_word k=%0d: got v=%b %0d/%h expected 1 %0d/00000000",
                         k, o_dump_valid, o_dump_addr, o_dump_data, k);
            end
            tick();
        end
        checks++;
        if (o_dump_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: got %b expected 1", o_dump_done);
        end
        i_dump_ready = 1'b0;
        tick();
    endtask

    initial begin
        i_reset = 1'b0; i_enable = 1'b0; i_RegWrite = 1'b0;
        i_write_reg = '0; i_write_data = '0;
        i_read_reg1 = '0; i_read_reg2 = '0;
        i_dump_start = 1'b0; i_dump_ready = 1'b0;
        tick();
        test_reset();
        test_write_read();
        test_reg_zero_enable();
        test_bypass();
        test_dump_backpressure();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
